// File: rtl/lpc_periph_mio.sv
// LPC peripheral target: decodes I/O (and optionally memory) read/write
// cycles, hands them to a local provider through level-signalled
// request/complete handshakes, and answers the host with SYNC/TAR nibbles.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for START (LFRAME# low, LAD=0000)
// CYC    | START seen; next nibble is the cycle type/direction
// ADDR   | shifting in address nibbles, MSB first; decode on the last one
// WDATA  | capturing two write-data nibbles, low nibble first
// HTAR   | host turnaround, two cycles, LAD released
// SYNC   | driving long-wait until the provider completes (or timeout)
// RDATA  | driving two read-data nibbles, low nibble first
// PTAR   | peripheral turnaround: 1111 driven, then released
// IGNORE | cycle not for us; wait for LFRAME# low
module lpc_periph_mio #(
    parameter logic [15:0] IO_BASE  = 16'h0080,
    parameter logic [15:0] IO_MASK  = 16'hFFF0,
    parameter bit          MEM_EN   = 1'b0,
    parameter logic [31:0] MEM_BASE = 32'hFF00_0000,
    parameter logic [31:0] MEM_MASK = 32'hFF00_0000,
    parameter logic [7:0]  WAIT_MAX = 8'd255
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        lframe_i,
    input  logic [3:0]  lad_i,
    output logic [3:0]  lad_o,
    output logic        lad_oe,
    output logic [31:0] addr_o,
    output logic        mem_o,
    output logic [7:0]  data_o,
    output logic        wr_o,
    input  logic        wr_done_i,
    output logic        rd_req_o,
    input  logic        rd_valid_i,
    input  logic [7:0]  data_i
);

    typedef enum logic [3:0] {
        IDLE,
        CYC,
        ADDR,
        WDATA,
        HTAR,
        SYNC,
        RDATA,
        PTAR,
        IGNORE
    } state_t;

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_LONG  = 4'b0110;
    localparam logic [3:0] SYNC_ERR   = 4'b1010;
    localparam logic [3:0] LAD_IDLE   = 4'b1111;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        is_wr, is_wr_nxt;
    logic        done, done_nxt;
    logic [7:0]  wait_cnt, wait_nxt;
    logic [7:0]  rd_data, rd_data_nxt;
    logic [3:0]  lad_o_nxt;
    logic        lad_oe_nxt;
    logic [31:0] addr_nxt;
    logic        mem_nxt;
    logic [7:0]  data_nxt;
    logic        wr_nxt;
    logic        rd_req_nxt;

    logic        wr_cpl;
    logic        rd_cpl;
    logic        enter_sync;
    logic        sync_final;
    logic [7:0]  wait_left;
    logic [31:0] addr_shift;
    logic        dec_hit;

    assign wr_cpl     = wr_o & wr_done_i;
    assign rd_cpl     = rd_req_o & rd_valid_i;
    assign sync_final = (lad_o == SYNC_READY) || (lad_o == SYNC_ERR);
    // The first SYNC nibble starts from the full budget; later ones count down.
    assign wait_left  = (state == SYNC) ? wait_cnt : WAIT_MAX;
    assign addr_shift = {addr_o[27:0], lad_i};
    assign dec_hit    = mem_o ? ((addr_shift & MEM_MASK) == (MEM_BASE & MEM_MASK))
                              : ((addr_shift[15:0] & IO_MASK) == (IO_BASE & IO_MASK));

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        is_wr_nxt   = is_wr;
        done_nxt    = done | wr_cpl | rd_cpl;
        wait_nxt    = wait_cnt;
        rd_data_nxt = rd_cpl ? data_i : rd_data;
        lad_o_nxt   = LAD_IDLE;
        lad_oe_nxt  = 1'b0;
        addr_nxt    = addr_o;
        mem_nxt     = mem_o;
        data_nxt    = data_o;
        wr_nxt      = wr_o & ~wr_done_i;
        rd_req_nxt  = rd_req_o & ~rd_valid_i;
        enter_sync  = 1'b0;

        if ((state != IDLE) && !lframe_i) begin
            // Abort (or START from IGNORE) beats everything else.
            state_nxt  = (lad_i == 4'b0000) ? CYC : IDLE;
            wr_nxt     = 1'b0;
            rd_req_nxt = 1'b0;
            done_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!lframe_i && (lad_i == 4'b0000)) begin
                        state_nxt = CYC;
                        done_nxt  = 1'b0;
                    end
                end
                CYC: begin
                    case (lad_i[3:1])
                        3'b000, 3'b001: begin
                            is_wr_nxt = lad_i[1];
                            mem_nxt   = 1'b0;
                            addr_nxt  = '0;
                            cnt_nxt   = 3'd3;
                            state_nxt = ADDR;
                        end
                        3'b010, 3'b011: begin
                            if (MEM_EN) begin
                                is_wr_nxt = lad_i[1];
                                mem_nxt   = 1'b1;
                                addr_nxt  = '0;
                                cnt_nxt   = 3'd7;
                                state_nxt = ADDR;
                            end else begin
                                state_nxt = IGNORE;
                            end
                        end
                        default: state_nxt = IGNORE;
                    endcase
                end
                ADDR: begin
                    addr_nxt = addr_shift;
                    if (cnt != 3'd0) begin
                        cnt_nxt = cnt - 3'd1;
                    end else if (!dec_hit) begin
                        state_nxt = IGNORE;
                    end else if (is_wr) begin
                        cnt_nxt   = 3'd1;
                        state_nxt = WDATA;
                    end else begin
                        rd_req_nxt = 1'b1;
                        cnt_nxt    = 3'd1;
                        state_nxt  = HTAR;
                    end
                end
                WDATA: begin
                    if (cnt[0]) begin
                        data_nxt[3:0] = lad_i;
                        cnt_nxt       = 3'd0;
                    end else begin
                        data_nxt[7:4] = lad_i;
                        wr_nxt        = 1'b1;
                        cnt_nxt       = 3'd1;
                        state_nxt     = HTAR;
                    end
                end
                HTAR: begin
                    if (cnt[0]) begin
                        cnt_nxt = 3'd0;
                    end else begin
                        enter_sync = 1'b1;
                    end
                end
                SYNC: begin
                    if (!sync_final) begin
                        enter_sync = 1'b1;
                    end else if (is_wr) begin
                        lad_oe_nxt = 1'b1;
                        cnt_nxt    = 3'd1;
                        state_nxt  = PTAR;
                    end else begin
                        lad_oe_nxt = 1'b1;
                        lad_o_nxt  = rd_data[3:0];
                        cnt_nxt    = 3'd1;
                        state_nxt  = RDATA;
                    end
                end
                RDATA: begin
                    lad_oe_nxt = 1'b1;
                    if (cnt[0]) begin
                        lad_o_nxt = rd_data[7:4];
                        cnt_nxt   = 3'd0;
                    end else begin
                        cnt_nxt   = 3'd1;
                        state_nxt = PTAR;
                    end
                end
                PTAR: begin
                    if (cnt[0]) begin
                        cnt_nxt = 3'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                IGNORE: begin
                    state_nxt = IGNORE;
                end
                default: state_nxt = IDLE;
            endcase
        end

        // One SYNC nibble: ready if completed (even on this very edge),
        // otherwise long-wait until the budget runs out, then error.
        if (enter_sync) begin
            state_nxt  = SYNC;
            lad_oe_nxt = 1'b1;
            if (done_nxt) begin
                lad_o_nxt = SYNC_READY;
            end else if (wait_left == 8'd0) begin
                lad_o_nxt   = SYNC_ERR;
                wr_nxt      = 1'b0;
                rd_req_nxt  = 1'b0;
                rd_data_nxt = 8'hFF;
            end else begin
                lad_o_nxt = SYNC_LONG;
                wait_nxt  = wait_left - 8'd1;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            is_wr    <= 1'b0;
            done     <= 1'b0;
            wait_cnt <= 8'd0;
            rd_data  <= 8'd0;
            lad_o    <= LAD_IDLE;
            lad_oe   <= 1'b0;
            addr_o   <= 32'd0;
            mem_o    <= 1'b0;
            data_o   <= 8'd0;
            wr_o     <= 1'b0;
            rd_req_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            is_wr    <= is_wr_nxt;
            done     <= done_nxt;
            wait_cnt <= wait_nxt;
            rd_data  <= rd_data_nxt;
            lad_o    <= lad_o_nxt;
            lad_oe   <= lad_oe_nxt;
            addr_o   <= addr_nxt;
            mem_o    <= mem_nxt;
            data_o   <= data_nxt;
            wr_o     <= wr_nxt;
            rd_req_o <= rd_req_nxt;
        end
    end

endmodule
